// File: rtl/peak_tx_arbiter_if.sv
// Signal bundle between the accumulate channels' tx FIFOs, the peak_tx_arbiter and the UART transmitter.
// master = arbiter side, slave = channel/UART side.
interface peak_tx_arbiter_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]   ChDataReady;
  logic [NUM_CH-1:0]   ChDataValid;
  logic [8*NUM_CH-1:0] ChDataOut;
  logic [NUM_CH-1:0]   ChTxEnable;
  logic                UartReady;
  logic                UartWrEn;
  logic [7:0]          UartData;
  logic [2:0]          GrantCh;
  logic                Busy;
  logic                TimeoutErr;
  logic [7:0]          TimeoutCount;

  modport master (
    input  ChDataReady, ChDataValid, ChDataOut, UartReady,
    output ChTxEnable, UartWrEn, UartData, GrantCh, Busy, TimeoutErr, TimeoutCount
  );

  modport slave (
    output ChDataReady, ChDataValid, ChDataOut, UartReady,
    input  ChTxEnable, UartWrEn, UartData, GrantCh, Busy, TimeoutErr, TimeoutCount
  );
endinterface

// File: rtl/peak_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_CH accumulate channels;
// each granted frame is prefixed with HDR_BASE|channel and ends on an aligned FF 80 stop word.
//
// state      | meaning
// IDLE       | no grant; pick next ready channel from the round-robin pointer
// HEADER     | wait for UART, write header byte
// REQ        | wait for UART and channel data, issue one read strobe
// WAIT_VALID | wait for the channel's valid byte, then forward it
// DONE       | advance pointer past the granted channel
module peak_tx_arbiter #(
  parameter int         NUM_CH   = 4,
  parameter int         TIMEOUT  = 65535,
  parameter logic [7:0] HDR_BASE = 8'hC0
) (
  input logic               SysClk,
  input logic               ResetN,
  peak_tx_arbiter_if.master bus
);

  localparam int            TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT);
  localparam logic [2:0]    LAST_CH  = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    REQ,
    WAIT_VALID,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        grant, grant_nxt;
  logic [2:0]        ptr, ptr_nxt;
  logic              parity, parity_nxt;
  logic              prev_ff, prev_ff_nxt;
  logic [TW-1:0]     tmr, tmr_nxt;
  logic [NUM_CH-1:0] tx_en, tx_en_nxt;
  logic              wr_en, wr_en_nxt;
  logic [7:0]        wr_data, wr_data_nxt;
  logic              busy;
  logic              to_err, to_err_nxt;
  logic [7:0]        to_cnt, to_cnt_nxt;
  logic              abandon;

  logic [7:0]  rdy_pad;
  logic [7:0]  vld_pad;
  logic [7:0]  oh_pad;
  logic [63:0] data_pad;
  logic        sel_ready;
  logic        sel_valid;
  logic [7:0]  sel_byte;
  logic        stop_word;
  logic        tmr_expire;
  logic        pick_found;
  logic [2:0]  pick_ch;

  function automatic logic [2:0] rr_idx(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return 3'(s);
  endfunction

  // Pad channel vectors to 8 lanes so GrantCh can index them directly for any NUM_CH.
  assign rdy_pad    = 8'(bus.ChDataReady);
  assign vld_pad    = 8'(bus.ChDataValid);
  assign data_pad   = 64'(bus.ChDataOut);
  assign sel_ready  = rdy_pad[grant];
  assign sel_valid  = vld_pad[grant];
  assign sel_byte   = data_pad[{grant, 3'b000} +: 8];
  assign oh_pad     = 8'b1 << grant;
  assign stop_word  = parity && prev_ff && (sel_byte == 8'h80);
  assign tmr_expire = (tmr <= TW'(1));

  always_comb begin
    pick_found = 1'b0;
    pick_ch    = 3'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!pick_found && rdy_pad[rr_idx(ptr, k)]) begin
        pick_found = 1'b1;
        pick_ch    = rr_idx(ptr, k);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    ptr_nxt     = ptr;
    parity_nxt  = parity;
    prev_ff_nxt = prev_ff;
    tmr_nxt     = tmr;
    tx_en_nxt   = '0;
    wr_en_nxt   = 1'b0;
    wr_data_nxt = wr_data;
    to_err_nxt  = 1'b0;
    to_cnt_nxt  = to_cnt;
    abandon     = 1'b0;

    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_ch;
          tmr_nxt   = TMR_LOAD;
          state_nxt = HEADER;
        end
      end

      HEADER: begin
        if (bus.UartReady) begin
          wr_en_nxt   = 1'b1;
          wr_data_nxt = HDR_BASE | {5'b00000, grant};
          parity_nxt  = 1'b0;
          prev_ff_nxt = 1'b0;
          tmr_nxt     = TMR_LOAD;
          state_nxt   = REQ;
        end
      end

      // A write issued last edge is still in flight while wr_en is high, so UartReady
      // cannot yet reflect it; holding off keeps the forwarded byte from overrunning the UART.
      REQ: begin
        if (tmr_expire) begin
          abandon = 1'b1;
        end else begin
          tmr_nxt = tmr - TW'(1);
          if (bus.UartReady && sel_ready && !wr_en) begin
            tx_en_nxt = oh_pad[NUM_CH-1:0];
            state_nxt = WAIT_VALID;
          end
        end
      end

      WAIT_VALID: begin
        if (sel_valid) begin
          wr_en_nxt   = 1'b1;
          wr_data_nxt = sel_byte;
          parity_nxt  = ~parity;
          prev_ff_nxt = (sel_byte == 8'hFF);
          tmr_nxt     = TMR_LOAD;
          state_nxt   = stop_word ? DONE : REQ;
        end else if (tmr_expire) begin
          abandon = 1'b1;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end

      DONE: begin
        ptr_nxt   = (grant == LAST_CH) ? 3'd0 : grant + 3'd1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    if (abandon) begin
      state_nxt  = DONE;
      to_err_nxt = 1'b1;
      to_cnt_nxt = (to_cnt == 8'hFF) ? to_cnt : to_cnt + 8'd1;
    end
  end

  always_ff @(posedge SysClk or negedge ResetN) begin
    if (!ResetN) begin
      state   <= IDLE;
      grant   <= 3'd0;
      ptr     <= 3'd0;
      parity  <= 1'b0;
      prev_ff <= 1'b0;
      tmr     <= '0;
      tx_en   <= '0;
      wr_en   <= 1'b0;
      wr_data <= 8'h00;
      busy    <= 1'b0;
      to_err  <= 1'b0;
      to_cnt  <= 8'h00;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      ptr     <= ptr_nxt;
      parity  <= parity_nxt;
      prev_ff <= prev_ff_nxt;
      tmr     <= tmr_nxt;
      tx_en   <= tx_en_nxt;
      wr_en   <= wr_en_nxt;
      wr_data <= wr_data_nxt;
      busy    <= (state_nxt != IDLE);
      to_err  <= to_err_nxt;
      to_cnt  <= to_cnt_nxt;
    end
  end

  assign bus.ChTxEnable   = tx_en;
  assign bus.UartWrEn     = wr_en;
  assign bus.UartData     = wr_data;
  assign bus.GrantCh      = grant;
  assign bus.Busy         = busy;
  assign bus.TimeoutErr   = to_err;
  assign bus.TimeoutCount = to_cnt;

endmodule

// File: doc/peak_tx_arbiter.md
Name: peak_tx_arbiter

Overview:
Shares the single UART byte transmitter among NUM_CH peak-accumulate channels. Each channel presents a byte-wide tx FIFO interface (ready/read-enable/valid/data). The arbiter grants one channel at a time in round-robin order and prefixes each frame with a channel header byte. It holds the grant until the channel's stop word has been forwarded, or until a timeout expires. It sits between the accumulate channels and the UART transmitter in the SysClk domain.

Parameters:
NUM_CH, 4, number of requesting accumulate channels (2..8)
TIMEOUT, 65535, SysClk cycles without a valid byte before a granted frame is abandoned
HDR_BASE, 8'hC0, header byte base; header = HDR_BASE | channel index

Ports:
SysClk  in  1  system clock, all logic on rising edge
ResetN  in  1  asynchronous active-low reset
ChDataReady  in  NUM_CH  per-channel: tx FIFO has data
ChDataValid  in  NUM_CH  per-channel: DataOut valid, one cycle after read enable
ChDataOut  in  8*NUM_CH  per-channel byte; channel i at [8i+7:8i]
ChTxEnable  out  NUM_CH  per-channel one-cycle read strobe
UartReady  in  1  transmitter can accept a byte; stays high until a write occurs
UartWrEn  out  1  one-cycle byte write strobe
UartData  out  8  byte to transmit
GrantCh  out  3  currently/last granted channel index
Busy  out  1  high whenever state != IDLE
TimeoutErr  out  1  one-cycle pulse when a frame is abandoned
TimeoutCount  out  8  saturating count of abandoned frames

Behaviour:
- Reset (ResetN low, async): state=IDLE, ChTxEnable=0, UartWrEn=0, UartData=0, GrantCh=0, Busy=0, TimeoutErr=0, TimeoutCount=0, round-robin pointer=0, byte-parity=0.
- All outputs are registered.
- States: IDLE, HEADER, REQ, WAIT_VALID, DONE.
- IDLE: if any ChDataReady is set, grant the first set bit searching from pointer upward, wrapping. Latch GrantCh, go to HEADER. Channels without ChDataReady are skipped.
- HEADER: when UartReady is high, UartWrEn=1 and UartData=HDR_BASE|GrantCh for one cycle; clear parity; go to REQ.
- REQ: when UartReady is high and ChDataReady[GrantCh] is high, pulse ChTxEnable[GrantCh] for one cycle; go to WAIT_VALID. Never more than one outstanding read.
- WAIT_VALID: when ChDataValid[GrantCh] is high, forward ChDataOut[GrantCh] with UartWrEn on the next edge (1-cycle latency) and toggle parity.
  - End of frame: the byte at parity=1 (second byte of a 16-bit word) is 8'h80 and the previous byte was 8'hFF. On end of frame go to DONE; otherwise go to REQ.
  - FF/80 at odd alignment is never treated as a stop.
- Timeout counter: cleared on entering HEADER and on every forwarded byte; counts in REQ and WAIT_VALID.
  - When it reaches TIMEOUT, go to DONE, pulse TimeoutErr, and increment TimeoutCount, saturating at 255.
  - A late ChDataValid arriving in DONE or IDLE is ignored.
- DONE: pointer = GrantCh+1, wrapping at NUM_CH; go to IDLE. Busy falls in IDLE.
- Valid bits on non-granted channels are ignored. A ChDataReady drop mid-frame only stalls REQ, which the timeout covers.
- ResetN asserted mid-frame aborts immediately. No partial byte is written after reset.
- Throughput: at most one byte per 3 cycles (REQ, WAIT_VALID, forward); UART pacing dominates.

Test Plan:
- Ch1 only, frame FF 20 12 34 FF 80 -> UART sequence C1 FF 20 12 34 FF 80; Busy falls 1-2 cycles after the 80 is written; pointer=2.
- Ch0 and ch2 ready simultaneously, pointer=0 -> ch0 frame (C0...) completes fully before C2 header; next pair of requests from ch0 and ch2 serves ch2 first.
- Frame containing word 12FF followed by word 8034 (odd-aligned FF,80) -> no stop; forwarding continues to the true FF 80.
- TIMEOUT=20, ch3 sends FF 20 then ChDataReady stays low -> TimeoutErr pulse at 20 idle cycles, TimeoutCount=1, state returns to IDLE, next ready channel is granted.
- UartReady held low 50 cycles during a frame -> no ChTxEnable issued; all bytes delivered in order once ready returns.
- ResetN pulsed low mid-frame -> all outputs reset immediately and asynchronously; after release the next request starts with a header byte.
